// File: rtl/bank_dispatch_ctrl.sv
// Single-outstanding request dispatcher for the 1-to-16 bank demux: latches the
// target bank, waits for it to be free, fires a one-cycle strobe, then reports ack or timeout.
module bank_dispatch_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_bank,
    output logic        req_ready,
    input  logic [15:0] bank_busy,
    output logic [3:0]  sel,
    output logic        strobe,
    input  logic        ack,
    output logic        done,
    output logic        err,
    output logic [3:0]  resp_bank
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      sel_q;
    logic [3:0]      resp_bank_q;
    logic            req_ready_q;
    logic            strobe_q;
    logic            done_q;
    logic            err_q;

    // Transaction FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 4'd0;
            resp_bank_q <= 4'd0;
            req_ready_q <= 1'b1;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        sel_q       <= req_bank;
                        resp_bank_q <= req_bank;
                        req_ready_q <= 1'b0;
                        if (bank_busy[req_bank]) begin
                            state_q <= HOLD;
                        end else begin
                            state_q  <= ISSUE;
                            strobe_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bank_busy[sel_q]) begin
                        state_q  <= ISSUE;
                        strobe_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // ack in the last counted cycle still beats the timeout
                    if (ack) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= RESP;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign sel       = sel_q;
    assign strobe    = strobe_q;
    assign done      = done_q;
    assign err       = err_q;
    assign resp_bank = resp_bank_q;

endmodule

// File: tb/tb_bank_dispatch_ctrl.sv
// Directed bench for bank_dispatch_ctrl built with TIMEOUT=4; inputs change and
// outputs are sampled on the falling edge.
module tb_bank_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_bank;
    logic        req_ready;
    logic [15:0] bank_busy;
    logic [3:0]  sel;
    logic        strobe;
    logic        ack;
    logic        done;
    logic        err;
    logic [3:0]  resp_bank;

    int errors = 0;
    int checks = 0;

    bank_dispatch_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bank  (req_bank),
        .req_ready (req_ready),
        .bank_busy (bank_busy),
        .sel       (sel),
        .strobe    (strobe),
        .ack       (ack),
        .done      (done),
        .err       (err),
        .resp_bank (resp_bank)
    );

    always #5 clk = ~clk;

    task test_reset;
        rst = 1'b1; req_valid = 1'b0; req_bank = 4'd0; bank_busy = 16'h0000; ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, strobe, done, err} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags: got rdy/stb/done/err=%b exp 1000", {req_ready, strobe, done, err});
        end
        checks++;
        if ({sel, resp_bank} !== 8'h00) begin
            errors++; $display("FAIL reset_sel: got sel=%0d resp_bank=%0d exp 0/0", sel, resp_bank);
        end
        for (int i = 0; i < 4; i++) begin
            ack = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if ({req_ready, strobe, done, err} !== 4'b1000) begin
                errors++; $display("FAIL idle_stray_ack%0d: got rdy/stb/done/err=%b exp 1000", i, {req_ready, strobe, done, err});
            end
        end
        ack = 1'b0;
    endtask

    task test_normal;
        req_valid = 1'b1; req_bank = 4'd9;
        @(negedge clk);                      // T+1
        req_valid = 1'b0; req_bank = 4'd2;
        checks++;
        if ({strobe, req_ready, sel} !== {1'b1, 1'b0, 4'd9}) begin
            errors++; $display("FAIL normal_t1: got stb=%b rdy=%b sel=%0d exp 1 0 9", strobe, req_ready, sel);
        end
        @(negedge clk);                      // T+2
        checks++;
        if ({strobe, done, sel} !== {1'b0, 1'b0, 4'd9}) begin
            errors++; $display("FAIL normal_t2: got stb=%b done=%b sel=%0d exp 0 0 9", strobe, done, sel);
        end
        @(negedge clk);                      // T+3
        ack = 1'b1;
        checks++;
        if ({done, sel} !== {1'b0, 4'd9}) begin
            errors++; $display("FAIL normal_t3: got done=%b sel=%0d exp 0 9", done, sel);
        end
        @(negedge clk);                      // T+4
        ack = 1'b0;
        checks++;
        if ({done, err, req_ready, resp_bank, sel} !== {1'b1, 1'b0, 1'b0, 4'd9, 4'd9}) begin
            errors++; $display("FAIL normal_done: got done=%b err=%b rdy=%b resp=%0d sel=%0d exp 1 0 0 9 9", done, err, req_ready, resp_bank, sel);
        end
        @(negedge clk);                      // T+5
        checks++;
        if ({req_ready, done} !== 2'b10) begin
            errors++; $display("FAIL normal_ready: got rdy=%b done=%b exp 1 0", req_ready, done);
        end
    endtask

    task test_busy;
        bank_busy = 16'h0008; req_valid = 1'b1; req_bank = 4'd3;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);                  // T+i, bank 3 still busy
            req_valid = 1'b0; req_bank = 4'd7;
            checks++;
            if ({strobe, req_ready, sel} !== {1'b0, 1'b0, 4'd3}) begin
                errors++; $display("FAIL busy_hold%0d: got stb=%b rdy=%b sel=%0d exp 0 0 3", i, strobe, req_ready, sel);
            end
        end
        @(negedge clk);                      // T+5
        bank_busy = 16'h0000;
        checks++;
        if (strobe !== 1'b0) begin
            errors++; $display("FAIL busy_last: got stb=%b exp 0", strobe);
        end
        @(negedge clk);                      // T+6
        checks++;
        if ({strobe, sel} !== {1'b1, 4'd3}) begin
            errors++; $display("FAIL busy_strobe: got stb=%b sel=%0d exp 1 3", strobe, sel);
        end
        @(negedge clk);                      // first WAIT cycle
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if ({done, err, resp_bank} !== {1'b1, 1'b0, 4'd3}) begin
            errors++; $display("FAIL busy_done: got done=%b err=%b resp=%0d exp 1 0 3", done, err, resp_bank);
        end
        @(negedge clk);
    endtask

    task test_timeout;
        req_valid = 1'b1; req_bank = 4'd15;
        @(negedge clk);                      // T+1
        req_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ({done, err, strobe} !== 3'b000) begin
                errors++; $display("FAIL timeout_wait%0d: got done/err/stb=%b exp 000", c, {done, err, strobe});
            end
        end
        @(negedge clk);                      // T+6
        checks++;
        if ({err, done, resp_bank} !== {1'b1, 1'b0, 4'd15}) begin
            errors++; $display("FAIL timeout_err: got err=%b done=%b resp=%0d exp 1 0 15", err, done, resp_bank);
        end
        @(negedge clk);                      // T+7: late ack
        ack = 1'b1;
        checks++;
        if ({req_ready, err, done} !== 3'b100) begin
            errors++; $display("FAIL timeout_idle: got rdy/err/done=%b exp 100", {req_ready, err, done});
        end
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if ({req_ready, strobe, done, err} !== 4'b1000) begin
            errors++; $display("FAIL timeout_late_ack: got rdy/stb/done/err=%b exp 1000", {req_ready, strobe, done, err});
        end
    endtask

    task test_boundary_ack;
        req_valid = 1'b1; req_bank = 4'd6;
        @(negedge clk);                      // T+1
        req_valid = 1'b0;
        repeat (4) @(negedge clk);           // T+5: fourth WAIT cycle
        ack = 1'b1;
        @(negedge clk);                      // T+6
        ack = 1'b0;
        checks++;
        if ({done, err, resp_bank} !== {1'b1, 1'b0, 4'd6}) begin
            errors++; $display("FAIL boundary_ack: got done=%b err=%b resp=%0d exp 1 0 6", done, err, resp_bank);
        end
        @(negedge clk);
        checks++;
        if ({req_ready, done, err} !== 3'b100) begin
            errors++; $display("FAIL boundary_after: got rdy/done/err=%b exp 100", {req_ready, done, err});
        end
    endtask

    task test_reset_mid_wait;
        req_valid = 1'b1; req_bank = 4'd5;
        @(negedge clk);                      // T+1
        req_valid = 1'b0;
        checks++;
        if ({strobe, sel} !== {1'b1, 4'd5}) begin
            errors++; $display("FAIL midrst_strobe: got stb=%b sel=%0d exp 1 5", strobe, sel);
        end
        repeat (2) @(negedge clk);           // T+3, inside WAIT
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, strobe, done, err, sel, resp_bank} !== {4'b1000, 4'd0, 4'd0}) begin
            errors++; $display("FAIL midrst_async: got rdy/stb/done/err=%b sel=%0d resp=%0d exp 1000 0 0", {req_ready, strobe, done, err}, sel, resp_bank);
        end
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack = 1'b0;
            checks++;
            if ({req_ready, done, err} !== 3'b100) begin
                errors++; $display("FAIL midrst_quiet%0d: got rdy/done/err=%b exp 100", i, {req_ready, done, err});
            end
        end
        req_valid = 1'b1; req_bank = 4'd0;
        @(negedge clk);                      // T+1
        req_valid = 1'b0;
        checks++;
        if ({strobe, sel, req_ready} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL midrst_next_strobe: got stb=%b sel=%0d rdy=%b exp 1 0 0", strobe, sel, req_ready);
        end
        @(negedge clk);                      // T+2, first WAIT cycle
        ack = 1'b1;
        @(negedge clk);                      // T+3
        ack = 1'b0;
        checks++;
        if ({done, err, resp_bank} !== {1'b1, 1'b0, 4'd0}) begin
            errors++; $display("FAIL midrst_next_done: got done=%b err=%b resp=%0d exp 1 0 0", done, err, resp_bank);
        end
        @(negedge clk);                      // T+4
        checks++;
        if ({req_ready, done} !== 2'b10) begin
            errors++; $display("FAIL midrst_next_ready: got rdy=%b done=%b exp 1 0", req_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_busy();
        test_timeout();
        test_boundary_ack();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bank_dispatch_ctrl.md
# bank_dispatch_ctrl

Single-master request dispatcher that sequences the 1-to-16 bank demux in the wired-OR instruction-cache interconnect. It accepts one request at a time with a 4-bit bank index and holds the demux select stable for the whole transaction. It waits for the target bank to be free, then fires a one-cycle strobe through the demux. It then waits for the wired-OR acknowledge and reports completion or timeout back to the master.

## Interface
- TIMEOUT, default 15: maximum WAIT cycles before error; legal range 1..255.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  master request present.
- req_bank  in  4  target bank index, sampled on accept.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- bank_busy  in  16  per-bank busy flags; bit n = bank n busy.
- sel  out  4  demux select; equals the latched bank index.
- strobe  out  1  demux data input; one-cycle issue pulse.
- ack  in  1  wired-OR acknowledge from all banks.
- done  out  1  one-cycle pulse: transaction acknowledged.
- err  out  1  one-cycle pulse: transaction timed out.
- resp_bank  out  4  bank of the completing transaction; valid with done/err.

## Operation
- States: IDLE, HOLD, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch req_bank into sel/resp_bank.
  - Next state is HOLD if bank_busy[req_bank]=1, else ISSUE.
- HOLD:
  - Wait while bank_busy[sel]=1, with no limit.
  - Go to ISSUE in the cycle after bank_busy[sel] reads 0.
- ISSUE:
  - strobe=1 for exactly one cycle.
  - Clear the timeout counter, then go to WAIT.
  - ack is ignored in ISSUE.
- WAIT:
  - If ack=1, record ok and go to RESP.
  - Else if counter == TIMEOUT-1, record timeout and go to RESP.
  - Else increment the counter.
  - ack in the final WAIT cycle wins over timeout.
- RESP:
  - Assert done (ok) or err (timeout) for one cycle; never both.
  - Next state is IDLE.
- Counter width is ceil(log2(TIMEOUT+1)) bits. The counter never wraps; it is reset on every entry into WAIT.
- sel is constant from the accept edge until the next accept, and holds its last value while in IDLE.
- All outputs decode from registers only; there is no combinational path from any input to any output.
- req_bank and bank_busy bits other than bank_busy[sel] are ignored outside the accept cycle.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: req_ready=1, sel=0, strobe=0, done=0, err=0, resp_bank=0.
  - Counter: 0.
- rst asserted mid-transaction aborts immediately:
  - strobe, done and err drop asynchronously.
  - No done/err is emitted for the aborted request.
- Accept at edge T with the bank free:
  - strobe high in cycle T+1.
  - WAIT starts at T+2.
- ack sampled high in WAIT cycle W: done high in W+1, req_ready high in W+2.
- Best case (ack in the first WAIT cycle): 4 cycles accept-to-accept.
- Timeout: err in cycle T+2+TIMEOUT; WAIT lasts exactly TIMEOUT cycles.
- ack outside WAIT is ignored, including stray or late acks from a timed-out transaction.
- Only one outstanding transaction; req_ready=0 in HOLD, ISSUE, WAIT and RESP.

## Test plan
- Reset then idle: hold rst 3 cycles, release → req_ready=1, sel=0, strobe=done=err=0; stray ack pulses produce nothing.
- Normal transfer: req_bank=9 with bank free, ack on the 2nd WAIT cycle → strobe one cycle at T+1, sel=9 throughout, done=1 and resp_bank=9 at T+4, req_ready back at T+5.
- Busy bank: req_bank=3 with bank_busy[3]=1 for 5 cycles and other banks free → no strobe until busy drops, strobe the cycle after, sel=3 throughout.
- Timeout: TIMEOUT=4, req_bank=15, no ack → err at T+6, done never asserted; an ack injected at T+7 is ignored.
- Boundary ack: TIMEOUT=4, ack exactly on the 4th WAIT cycle → done=1, err=0.
- Reset mid-WAIT: assert rst two cycles after strobe → outputs return to reset values asynchronously, no done/err, next request (bank 0) completes normally.
